// File: rtl/mem_burst_pkg.sv
// Shared types and widths for the frame-buffer burst responder.
package mem_burst_pkg;

    localparam int LEN_BITS     = 10;
    localparam int ADDR_IN_BITS = 27;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_END,
        RD_DATA,
        RD_END,
        GAP
    } state_t;

endpackage

// File: rtl/mem_burst_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, one-cycle read latency.
module mem_burst_ram #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_BITS-1:0]     waddr,
    input  logic [MEM_DATA_BITS-1:0] wdata,
    input  logic                     re,
    input  logic [ADDR_BITS-1:0]     raddr,
    output logic [MEM_DATA_BITS-1:0] rdata
);

    logic [MEM_DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register holds its value between bursts; only it is cleared by reset, never the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_burst_responder.sv
// Burst responder: arbitrates one write and one read client, runs one burst at a time on on-chip RAM.
// Define MEM_BURST_RR_EN for round-robin arbitration; default build gives write fixed priority.
module mem_burst_responder
    import mem_burst_pkg::*;
#(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 12
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic                     wr_burst_req,
    input  logic [LEN_BITS-1:0]      wr_burst_len,
    input  logic [ADDR_IN_BITS-1:0]  wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish,
    input  logic                     rd_burst_req,
    input  logic [LEN_BITS-1:0]      rd_burst_len,
    input  logic [ADDR_IN_BITS-1:0]  rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish
);

    state_t               state;
    logic [ADDR_BITS-1:0] burst_addr;
    logic [LEN_BITS-1:0]  burst_len;
    logic [LEN_BITS-1:0]  beat_cnt;
    logic                 end_phase;
    logic [ADDR_BITS-1:0] beat_addr;
    logic                 grant_wr;
    logic                 grant_rd;
    logic                 rd_en;
    logic                 wr_en_p1;
    logic [ADDR_BITS-1:0] wr_addr_p1;
    logic                 unused_addr_hi;

    // Address arithmetic wraps silently at the RAM end.
    assign beat_addr      = burst_addr + ADDR_BITS'(beat_cnt);
    assign rd_en          = (state == RD_DATA);
    assign unused_addr_hi = ^{wr_burst_addr[ADDR_IN_BITS-1:ADDR_BITS],
                              rd_burst_addr[ADDR_IN_BITS-1:ADDR_BITS]};

`ifdef MEM_BURST_RR_EN
    logic last_rd;
    assign grant_wr = wr_burst_req && !(rd_burst_req && !last_rd);
    assign grant_rd = rd_burst_req && !(wr_burst_req && last_rd);
`else
    assign grant_wr = wr_burst_req;
    assign grant_rd = rd_burst_req && !wr_burst_req;
`endif

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            beat_cnt            <= '0;
            end_phase           <= 1'b0;
            wr_burst_data_req   <= 1'b0;
            wr_burst_finish     <= 1'b0;
            rd_burst_data_valid <= 1'b0;
            rd_burst_finish     <= 1'b0;
            wr_en_p1            <= 1'b0;
`ifdef MEM_BURST_RR_EN
            last_rd             <= 1'b1;
`endif
        end else begin
            wr_en_p1            <= wr_burst_data_req;
            rd_burst_data_valid <= rd_en;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (grant_wr) begin
                        wr_burst_data_req <= (wr_burst_len != '0);
                        state             <= (wr_burst_len != '0) ? WR_DATA : WR_END;
                    end else if (grant_rd) begin
                        state <= (rd_burst_len != '0) ? RD_DATA : RD_END;
                    end
`ifdef MEM_BURST_RR_EN
                    if (grant_wr || grant_rd) last_rd <= grant_rd;
`endif
                end
                WR_DATA, RD_DATA: begin
                    if (beat_cnt == burst_len - LEN_BITS'(1)) begin
                        beat_cnt          <= '0;
                        wr_burst_data_req <= 1'b0;
                        state             <= (state == WR_DATA) ? WR_END : RD_END;
                    end else begin
                        beat_cnt <= beat_cnt + LEN_BITS'(1);
                    end
                end
                // First END cycle lets the last write commit / last read beat drain; second carries finish.
                WR_END, RD_END: begin
                    end_phase       <= !end_phase;
                    wr_burst_finish <= !end_phase && (state == WR_END);
                    rd_burst_finish <= !end_phase && (state == RD_END);
                    if (end_phase) state <= GAP;
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge mem_clk) begin
        wr_addr_p1 <= beat_addr;
        if (state == IDLE) begin
            burst_addr <= grant_wr ? wr_burst_addr[ADDR_BITS-1:0] : rd_burst_addr[ADDR_BITS-1:0];
            burst_len  <= grant_wr ? wr_burst_len : rd_burst_len;
        end
    end

    mem_burst_ram #(
        .MEM_DATA_BITS(MEM_DATA_BITS),
        .ADDR_BITS    (ADDR_BITS)
    ) u_ram (
        .clk  (mem_clk),
        .rst_n(rst_n),
        .we   (wr_en_p1),
        .waddr(wr_addr_p1),
        .wdata(wr_burst_data),
        .re   (rd_en),
        .raddr(beat_addr),
        .rdata(rd_burst_data)
    );

endmodule

// File: tb/tb_mem_burst_responder.sv
// Scoreboard bench for mem_burst_responder: directed bursts queue expected events, a monitor pops them.
module tb_mem_burst_responder;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] data;
    } exp_t;

    localparam int K_DREQ = 0;
    localparam int K_WFIN = 1;
    localparam int K_RVLD = 2;
    localparam int K_RFIN = 3;

    logic        mem_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_burst_req = 1'b0;
    logic [9:0]  wr_burst_len = '0;
    logic [26:0] wr_burst_addr = '0;
    logic        wr_burst_data_req;
    logic [63:0] wr_burst_data = '0;
    logic        wr_burst_finish;
    logic        rd_burst_req = 1'b0;
    logic [9:0]  rd_burst_len = '0;
    logic [26:0] rd_burst_addr = '0;
    logic        rd_burst_data_valid;
    logic [63:0] rd_burst_data;
    logic        rd_burst_finish;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [63:0] wq[$];

    mem_burst_responder #(.MEM_DATA_BITS(64), .ADDR_BITS(12)) dut (
        .mem_clk            (mem_clk),
        .rst_n              (rst_n),
        .wr_burst_req       (wr_burst_req),
        .wr_burst_len       (wr_burst_len),
        .wr_burst_addr      (wr_burst_addr),
        .wr_burst_data_req  (wr_burst_data_req),
        .wr_burst_data      (wr_burst_data),
        .wr_burst_finish    (wr_burst_finish),
        .rd_burst_req       (rd_burst_req),
        .rd_burst_len       (rd_burst_len),
        .rd_burst_addr      (rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_data      (rd_burst_data),
        .rd_burst_finish    (rd_burst_finish)
    );

    always #5 mem_clk = ~mem_clk;
    always @(posedge mem_clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_DREQ:  return "wr_data_req";
            K_WFIN:  return "wr_finish";
            K_RVLD:  return "rd_valid";
            default: return "rd_finish";
        endcase
    endfunction

    task automatic push_exp(input int c, input int k, input logic [63:0] d);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.kind = k;
        e.data = d;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].cyc > c) i--;
        exp_q.insert(i, e);
    endtask

    task automatic check_evt(input int k, input logic [63:0] d);
        int idx = -1;
        n_chk++;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].kind == k) idx = i;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL %s: asserted at cycle %0d, no such event expected", kname(k), cyc);
        end else begin
            if (k == K_RVLD && d !== exp_q[idx].data) begin
                n_fail++;
                $display("FAIL rd_data at cycle %0d: got %h expected %h", cyc, d, exp_q[idx].data);
            end
            exp_q.delete(idx);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every asserted output must match a queued expectation at this cycle.
    always @(negedge mem_clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: expected at cycle %0d, not seen by cycle %0d",
                     kname(exp_q[0].kind), exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (wr_burst_data_req === 1'b1)   check_evt(K_DREQ, '0);
        if (wr_burst_finish === 1'b1)     check_evt(K_WFIN, '0);
        if (rd_burst_data_valid === 1'b1) check_evt(K_RVLD, rd_burst_data);
        if (rd_burst_finish === 1'b1)     check_evt(K_RFIN, '0);
    end

    // Write-data client: present the next queued word the cycle after each data_req.
    initial forever begin
        @(negedge mem_clk);
        if (wr_burst_data_req === 1'b1) begin
            @(posedge mem_clk);
            #1;
            if (wq.size() > 0) wr_burst_data = wq.pop_front();
            else               wr_burst_data = 64'hDEAD;
        end
    end

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge mem_clk);
            #1;
        end
    endtask

    task automatic exp_wr(input int t0, input int n);
        for (int k = 1; k <= n; k++) push_exp(t0 + k, K_DREQ, '0);
        push_exp(t0 + n + 2, K_WFIN, '0);
    endtask

    task automatic exp_rd(input int t0, input int n, input logic [63:0] base);
        for (int k = 0; k < n; k++) push_exp(t0 + 2 + k, K_RVLD, base + 64'(k));
        push_exp(t0 + n + 2, K_RFIN, '0);
    endtask

    task automatic wburst(input int t0, input logic [26:0] a, input int n, input logic [63:0] base);
        at(t0);
        wr_burst_req  = 1'b1;
        wr_burst_addr = a;
        wr_burst_len  = 10'(n);
        for (int k = 0; k < n; k++) wq.push_back(base + 64'(k));
        exp_wr(t0, n);
        at(t0 + n + 3);
        wr_burst_req = 1'b0;
    endtask

    task automatic rburst(input int t0, input logic [26:0] a, input int n, input logic [63:0] base);
        at(t0);
        rd_burst_req  = 1'b1;
        rd_burst_addr = a;
        rd_burst_len  = 10'(n);
        exp_rd(t0, n, base);
        at(t0 + n + 3);
        rd_burst_req = 1'b0;
    endtask

    initial begin
        at(2);
        @(negedge mem_clk);
        chk("reset wr_data_req", 64'(wr_burst_data_req), 64'd0);
        chk("reset wr_finish", 64'(wr_burst_finish), 64'd0);
        chk("reset rd_valid", 64'(rd_burst_data_valid), 64'd0);
        chk("reset rd_finish", 64'(rd_burst_finish), 64'd0);
        chk("reset rd_data", rd_burst_data, 64'd0);
        at(3);
        rst_n = 1'b1;

        // Basic write then readback
        wburst(4, 27'h10, 4, 64'd1);
        rburst(12, 27'h10, 4, 64'd1);
        chk("rd_data hold", rd_burst_data, 64'd4);

        // Contention twice: first always write, second depends on arbitration mode
        at(20);
        wr_burst_req  = 1'b1;
        wr_burst_addr = 27'h20;
        wr_burst_len  = 10'd2;
        wq.push_back(64'hA1);
        wq.push_back(64'hA2);
        rd_burst_req  = 1'b1;
        rd_burst_addr = 27'h20;
        rd_burst_len  = 10'd2;
        exp_wr(20, 2);
        at(25);
        wr_burst_addr = 27'h30;
        wr_burst_len  = 10'd1;
        wq.push_back(64'hB1);
`ifdef MEM_BURST_RR_EN
        exp_rd(26, 2, 64'hA1);
        exp_wr(32, 1);
        at(31);
        rd_burst_req = 1'b0;
        at(36);
        wr_burst_req = 1'b0;
`else
        exp_wr(26, 1);
        exp_rd(31, 2, 64'hA1);
        at(30);
        wr_burst_req = 1'b0;
        at(36);
        rd_burst_req = 1'b0;
`endif

        // Wrap at RAM end; upper address bits ignored
        wburst(37, 27'h4ABCFFE, 3, 64'hC1);
        rburst(44, 27'h0000000, 1, 64'hC3);
        rburst(49, 27'h7FFFFFF, 2, 64'hC2);

        // Zero-length bursts
        wburst(55, 27'h100, 0, 64'd0);
        rburst(59, 27'h100, 0, 64'd0);

        // Reset during beat 2 of a len-8 read
        at(63);
        rd_burst_req  = 1'b1;
        rd_burst_addr = 27'h10;
        rd_burst_len  = 10'd8;
        push_exp(65, K_RVLD, 64'd1);
        push_exp(66, K_RVLD, 64'd2);
        at(66);
        rst_n = 1'b0;
        at(67);
        rd_burst_req = 1'b0;
        @(negedge mem_clk);
        chk("midreset rd_valid", 64'(rd_burst_data_valid), 64'd0);
        chk("midreset rd_finish", 64'(rd_burst_finish), 64'd0);
        chk("midreset wr_data_req", 64'(wr_burst_data_req), 64'd0);
        chk("midreset wr_finish", 64'(wr_burst_finish), 64'd0);
        chk("midreset rd_data", rd_burst_data, 64'd0);
        at(68);
        rst_n = 1'b1;
        rburst(69, 27'h10, 4, 64'd1);

        // Back-to-back writes with request held: second grant N+4 cycles later
        at(77);
        wr_burst_req  = 1'b1;
        wr_burst_addr = 27'h40;
        wr_burst_len  = 10'd2;
        wq.push_back(64'hD1);
        wq.push_back(64'hD2);
        wq.push_back(64'hE1);
        wq.push_back(64'hE2);
        exp_wr(77, 2);
        exp_wr(83, 2);
        at(88);
        wr_burst_req = 1'b0;
        rburst(89, 27'h40, 2, 64'hE1);

        at(100);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
